time_set_buttons: RTL and testbench

Front end for the wall clock's time-setting buttons. Synchronises and debounces the raw minute and hour push-buttons. Emits single-cycle increment pulses: one per press, plus auto-repeat while a button is held. Sits between the board button pins and the wall-clock counter logic, which adds one to minutes or hours for each pulse.

---
 rtl/time_set_buttons_pkg.sv | 24 ++
 rtl/time_set_buttons_channel.sv | 103 ++++++++++
 rtl/time_set_buttons.sv | 44 ++++
 tb/tb_time_set_buttons.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/time_set_buttons_pkg.sv
// Shared constants for the wall-clock time-setting buttons: repeat FSM
// encoding, 100 MHz default timings and a counter width helper.
package time_set_buttons_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEFAULT_HOLD_CYCLES     = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES   = 10_000_000;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/time_set_buttons_channel.sv
// One time-setting button: 2-flop synchroniser, debouncer and
// press/hold/auto-repeat FSM producing single-cycle increment pulses.
module set_button_channel
    import time_set_buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic button_raw,
    output logic button,
    output logic inc
);

    localparam int DW = width_for(DEBOUNCE_CYCLES);
    localparam int TW = width_for(max_int(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] timer;
    logic [1:0]    state;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= button_raw;
            sync_q2 <= sync_q1;
        end
    end

    // The counter clears on the flip itself, so it can never pass DEB_LAST.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
            button  <= 1'b0;
        end else if (sync_q2 == button) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            button  <= sync_q2;
        end else begin
            deb_cnt <= deb_cnt + DW'(1);
        end
    end

    // A high level seen in IDLE is always a fresh rising edge: the FSM only
    // re-enters IDLE once the debounced level has already dropped.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            inc   <= 1'b0;
        end else begin
            inc <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (button) begin
                        inc   <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!button) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == HOLD_LAST) begin
                        inc   <= 1'b1;
                        timer <= '0;
                        state <= REPEAT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (!button) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == REPEAT_LAST) begin
                        inc   <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_set_buttons.sv
// Minute and hour time-setting buttons for the wall clock; each drives an
// independent channel that feeds increment pulses to the clock counters.
module time_set_buttons
    import time_set_buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic MButton_raw,
    input  logic HButton_raw,
    output logic MButton,
    output logic HButton,
    output logic min_inc,
    output logic hour_inc
);

    set_button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_minute (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .button_raw(MButton_raw),
        .button    (MButton),
        .inc       (min_inc)
    );

    set_button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_hour (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .button_raw(HButton_raw),
        .button    (HButton),
        .inc       (hour_inc)
    );

endmodule

// File: tb/tb_time_set_buttons.sv
// Directed bench for time_set_buttons: expected pulse cycles are queued per
// channel and matched against every observed min_inc/hour_inc pulse.
module tb_time_set_buttons;

    localparam int DEB = 4;
    localparam int HLD = 20;
    localparam int REP = 5;

    logic CLK100MHZ   = 1'b0;
    logic reset       = 1'b1;
    logic MButton_raw = 1'b0;
    logic HButton_raw = 1'b0;
    logic MButton;
    logic HButton;
    logic min_inc;
    logic hour_inc;

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;
    int mQ[$];
    int hQ[$];

    time_set_buttons #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .MButton_raw(MButton_raw),
        .HButton_raw(HButton_raw),
        .MButton    (MButton),
        .HButton    (HButton),
        .min_inc    (min_inc),
        .hour_inc   (hour_inc)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Cycle n is the interval just after posedge n counted from the last reset release.
    task automatic goTo(input int rel);
        while (cyc - base < rel) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic applyStimulus(input string name);
        $display("[TB] %s", name);
        @(posedge CLK100MHZ);
        #1;
        reset       = 1'b1;
        MButton_raw = 1'b0;
        HButton_raw = 1'b0;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        checkOutput("reset_MButton", 32'(MButton), 32'd0);
        checkOutput("reset_HButton", 32'(HButton), 32'd0);
        checkOutput("reset_min_inc", 32'(min_inc), 32'd0);
        checkOutput("reset_hour_inc", 32'(hour_inc), 32'd0);
        reset = 1'b0;
        base  = cyc;
    endtask

    // Held button: first pulse, then HLD later, then every REP, up to the
    // last cycle at which the debounced level is still high.
    function automatic void pushTrain(input bit hour, input int first, input int last);
        int p;
        p = first;
        if (hour) hQ.push_back(p); else mQ.push_back(p);
        p = p + HLD;
        while (p <= last) begin
            if (hour) hQ.push_back(p); else mQ.push_back(p);
            p = p + REP;
        end
    endfunction

    task automatic checkDrained(input string name);
        checkOutput({name, "_min_left"}, 32'(mQ.size()), 32'd0);
        checkOutput({name, "_hour_left"}, 32'(hQ.size()), 32'd0);
        mQ.delete();
        hQ.delete();
    endtask

    always @(negedge CLK100MHZ) begin : monitor
        int expM;
        int expH;
        if (!reset) begin
            if (min_inc === 1'b1) begin
                expM = (mQ.size() > 0) ? mQ.pop_front() : -1;
                checkOutput("min_inc_cycle", 32'(cyc - base), 32'(expM));
            end
            if (hour_inc === 1'b1) begin
                expH = (hQ.size() > 0) ? hQ.pop_front() : -1;
                checkOutput("hour_inc_cycle", 32'(cyc - base), 32'(expH));
            end
        end
    end

    initial begin : stimulus
        int bt[7];
        bt = '{10, 12, 14, 16, 18, 19, 20};

        applyStimulus("clean press");
        pushTrain(1'b0, 10 + DEB + 3, 25 + DEB + 2);
        goTo(10); MButton_raw = 1'b1;
        goTo(10 + DEB + 1); checkOutput("clean_level_before", 32'(MButton), 32'd0);
        goTo(10 + DEB + 2); checkOutput("clean_level_rise", 32'(MButton), 32'd1);
        goTo(25); MButton_raw = 1'b0;
        goTo(25 + DEB + 1); checkOutput("clean_level_held", 32'(MButton), 32'd1);
        goTo(25 + DEB + 2); checkOutput("clean_level_fall", 32'(MButton), 32'd0);
        goTo(60);
        checkDrained("clean");

        applyStimulus("bounce");
        pushTrain(1'b0, 20 + DEB + 3, 30 + DEB + 2);
        for (int i = 0; i < 7; i++) begin
            goTo(bt[i]);
            MButton_raw = (i % 2 == 0);
        end
        goTo(20 + DEB + 1); checkOutput("bounce_level_before", 32'(MButton), 32'd0);
        goTo(20 + DEB + 2); checkOutput("bounce_level_rise", 32'(MButton), 32'd1);
        goTo(30); MButton_raw = 1'b0;
        goTo(60);
        checkDrained("bounce");

        applyStimulus("hold hour");
        pushTrain(1'b1, 10 + DEB + 3, 65 + DEB + 2);
        goTo(10); HButton_raw = 1'b1;
        goTo(40); checkOutput("hold_HButton", 32'(HButton), 32'd1);
        checkOutput("hold_MButton", 32'(MButton), 32'd0);
        goTo(65); HButton_raw = 1'b0;
        goTo(100);
        checkDrained("hold");

        applyStimulus("simultaneous");
        pushTrain(1'b0, 10 + DEB + 3, 20 + DEB + 2);
        pushTrain(1'b1, 10 + DEB + 3, 20 + DEB + 2);
        goTo(10); MButton_raw = 1'b1; HButton_raw = 1'b1;
        goTo(20); MButton_raw = 1'b0; HButton_raw = 1'b0;
        goTo(50);
        checkDrained("simul");

        applyStimulus("reset mid-repeat");
        pushTrain(1'b0, 10 + DEB + 3, 44);
        pushTrain(1'b0, 50 + DEB + 3, 75 + DEB + 2);
        goTo(10); MButton_raw = 1'b1;
        goTo(44); checkOutput("rst_level_pre", 32'(MButton), 32'd1);
        goTo(45);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_MButton", 32'(MButton), 32'd0);
        checkOutput("rst_async_min_inc", 32'(min_inc), 32'd0);
        goTo(50);
        #2 reset = 1'b0;
        goTo(75); MButton_raw = 1'b0;
        goTo(110);
        checkDrained("reset");

        applyStimulus("glitch in repeat");
        pushTrain(1'b0, 10 + DEB + 3, 80 + DEB + 2);
        goTo(10); MButton_raw = 1'b1;
        goTo(50); MButton_raw = 1'b0;
        goTo(52); MButton_raw = 1'b1;
        goTo(55); checkOutput("glitch_level", 32'(MButton), 32'd1);
        goTo(80); MButton_raw = 1'b0;
        goTo(110);
        checkDrained("glitch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
